// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Even parity is the XOR of the byte; odd parity inverts it.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Free-running within a frame, held at zero while the transmitter idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign bit_tick = (cnt_r == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and serialises each one as a UART frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_r;
    logic [7:0]     shift_r;
    logic           parity_r;
    logic [2:0]     bit_cnt_r;
    logic           stop_cnt_r;
    logic           tick_s;
    logic           clear_s;

    assign clear_s = (state_r == IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .bit_tick (tick_s)
    );

    // Frame sequencer; every output is a register so tx never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= 8'd0;
            parity_r   <= 1'b0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            fifo_rd    <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_rd    <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        shift_r    <= fifo_data;
                        parity_r   <= parity_bit(fifo_data, PARITY_ODD != 0);
                        bit_cnt_r  <= 3'd0;
                        stop_cnt_r <= 1'b0;
                        fifo_rd    <= 1'b1;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s) begin
                        tx      <= shift_r[0];
                        shift_r <= shift_r >> 1;
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx      <= parity_r;
                                state_r <= PARITY;
                            end else begin
                                tx      <= 1'b1;
                                state_r <= STOP;
                            end
                        end else begin
                            tx        <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        tx      <= 1'b1;
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state_r    <= IDLE;
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three transmitter instances (plain, even+2 stop, odd+2 stop) fed by FIFO models.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        int          inst;
        logic [11:0] bits;
        int          t;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  enable_v = 3'b000;
    logic [2:0]  empty_v;
    logic [7:0]  data_v [3];
    wire  [2:0]  rd_v;
    wire  [2:0]  tx_v;
    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;

    logic [7:0]  mem [3][16];
    int          wp [3] = '{0, 0, 0};
    int          rp [3] = '{0, 0, 0};
    int          cyc = 0;

    int          rd_cnt [3]   = '{0, 0, 0};
    int          rd_hi [3]    = '{0, 0, 0};
    int          rd_cyc [3]   = '{0, 0, 0};
    int          done_cnt [3] = '{0, 0, 0};
    int          done_cyc [3] = '{0, 0, 0};
    logic [2:0]  rd_prev = 3'b000;

    frame_t      exp_q [$];
    frame_t      rx_q [$];
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable_v[0]), .fifo_empty(empty_v[0]), .fifo_data(data_v[0]),
        .fifo_rd(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable_v[1]), .fifo_empty(empty_v[1]), .fifo_data(data_v[1]),
        .fifo_rd(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable_v[2]), .fifo_empty(empty_v[2]), .fifo_data(data_v[2]),
        .fifo_rd(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

    // Show-ahead FIFO models.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty_v[i] = (wp[i] == rp[i]);
            data_v[i]  = mem[i][rp[i] % 16];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rd_v[i] && (wp[i] != rp[i])) rp[i] <= rp[i] + 1;
        end
    end

    // Pulse counters and timestamps.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_v[i]) begin
                rd_hi[i] <= rd_hi[i] + 1;
                if (!rd_prev[i]) begin
                    rd_cnt[i] <= rd_cnt[i] + 1;
                    rd_cyc[i] <= cyc;
                end
            end
            if (done_v[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_cyc[i] <= cyc;
            end
        end
        rd_prev <= rd_v;
    end

    function automatic logic [11:0] frame_for(input int inst, input logic [7:0] d);
        logic [11:0] f;
        f      = 12'hFFF;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (inst == 1) f[9] = ^d;
        if (inst == 2) f[9] = ~(^d);
        return f;
    endfunction

    task automatic push(input int inst, input logic [7:0] d, input bit expect_it);
        frame_t e;
        mem[inst][wp[inst] % 16] = d;
        wp[inst] = wp[inst] + 1;
        if (expect_it) begin
            e.inst = inst;
            e.bits = frame_for(inst, d);
            e.t    = 0;
            exp_q.push_back(e);
        end
    endtask

    // Decodes frames by sampling mid-bit; frames cut by reset are dropped.
    task automatic monitor(input int inst, input int nbits);
        logic   prev;
        frame_t r;
        bit     abort;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && (tx_v[inst] === 1'b0)) begin
                r.inst = inst;
                r.bits = 12'hFFF;
                r.t    = cyc;
                abort  = 1'b0;
                for (int off = 1; off <= (nbits - 1) * CPB + CPB / 2; off++) begin
                    @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                    if ((off % CPB) == CPB / 2) r.bits[off / CPB] = tx_v[inst];
                end
                if (!abort) rx_q.push_back(r);
            end
            prev = tx_v[inst];
        end
    endtask

    initial monitor(0, 10);
    initial monitor(1, 12);
    initial monitor(2, 12);

    task automatic wait_frames(input int inst, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cnt[inst] >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_v, busy_v, rd_v, done_v} !== 12'b111_000_000_000) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b expected %b", {tx_v, busy_v, rd_v, done_v}, 12'b111_000_000_000);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_a5();
        int r0; int d0; bit ok; frame_t r; frame_t e;
        r0 = rd_cnt[0]; d0 = done_cnt[0];
        push(0, 8'hA5, 1'b1);
        enable_v[0] = 1'b1;
        wait_frames(0, d0 + 1, 200, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL a5_timeout: got no frame_done expected one"); end
        n_cmp++;
        if (rx_q.size() != 1 || exp_q.size() != 1) begin
            n_mis++; $display("FAIL a5_frames: got %0d expected 1", rx_q.size());
        end else begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r.bits !== e.bits) begin n_mis++; $display("FAIL a5_bits: got %b expected %b", r.bits, e.bits); end
            n_cmp++;
            if (r.bits[9:0] !== 10'b1101001010) begin n_mis++; $display("FAIL a5_literal: got %b expected %b", r.bits[9:0], 10'b1101001010); end
        end
        n_cmp++;
        if (rd_cnt[0] - r0 != 1 || rd_hi[0] - r0 != 1) begin n_mis++; $display("FAIL a5_pops: got %0d expected 1", rd_hi[0] - r0); end
        n_cmp++;
        if (done_cyc[0] - rd_cyc[0] != 40) begin n_mis++; $display("FAIL a5_length: got %0d expected 40", done_cyc[0] - rd_cyc[0]); end
        n_cmp++;
        if ({empty_v[0], tx_v[0], busy_v[0]} !== 3'b110) begin
            n_mis++; $display("FAIL a5_after: got %b expected 110", {empty_v[0], tx_v[0], busy_v[0]});
        end
    endtask

    task automatic test_back_to_back();
        int r0; int h0; int d0; int tprev; bit ok; frame_t r; frame_t e;
        r0 = rd_cnt[0]; h0 = rd_hi[0]; d0 = done_cnt[0]; tprev = 0;
        enable_v[0] = 1'b0;
        push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b1);
        enable_v[0] = 1'b1;
        wait_frames(0, d0 + 3, 400, ok);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL b2b_timeout: got %0d frames expected 3", done_cnt[0] - d0); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_mis++; $display("FAIL b2b_missing: got no frame %0d expected one", k);
            end else begin
                r = rx_q.pop_front(); e = exp_q.pop_front();
                if (r.bits !== e.bits) begin n_mis++; $display("FAIL b2b_bits: got %b expected %b", r.bits, e.bits); end
                if (k > 0) begin
                    n_cmp++;
                    if (r.t - tprev != 41) begin n_mis++; $display("FAIL b2b_period: got %0d expected 41", r.t - tprev); end
                end
                tprev = r.t;
            end
        end
        n_cmp++;
        if (rd_cnt[0] - r0 != 3 || rd_hi[0] - h0 != 3) begin n_mis++; $display("FAIL b2b_pops: got %0d expected 3", rd_hi[0] - h0); end
        n_cmp++;
        if ({tx_v[0], busy_v[0]} !== 2'b10) begin n_mis++; $display("FAIL b2b_idle: got %b expected 10", {tx_v[0], busy_v[0]}); end
        enable_v[0] = 1'b0;
    endtask

    task automatic test_parity();
        bit ok; frame_t r; frame_t e;
        for (int inst = 1; inst <= 2; inst++) begin
            push(inst, 8'h07, 1'b1);
            enable_v[inst] = 1'b1;
            wait_frames(inst, done_cnt[inst] + 1, 300, ok);
            repeat (3) @(negedge clk);
            n_cmp++;
            if (!ok || rx_q.size() != 1) begin
                n_mis++; $display("FAIL par_frame%0d: got %0d frames expected 1", inst, rx_q.size());
            end else begin
                r = rx_q.pop_front(); e = exp_q.pop_front();
                if (r.bits !== e.bits) begin n_mis++; $display("FAIL par_bits%0d: got %b expected %b", inst, r.bits, e.bits); end
                n_cmp++;
                if (r.bits[9] !== ((inst == 1) ? 1'b1 : 1'b0)) begin
                    n_mis++; $display("FAIL par_bit%0d: got %b expected %b", inst, r.bits[9], (inst == 1) ? 1'b1 : 1'b0);
                end
            end
            n_cmp++;
            if (done_cyc[inst] - rd_cyc[inst] != 48) begin
                n_mis++; $display("FAIL par_length%0d: got %0d expected 48", inst, done_cyc[inst] - rd_cyc[inst]);
            end
            enable_v[inst] = 1'b0;
        end
    endtask

    task automatic test_empty_idle();
        bit rd_seen; bit tx_low; int r0;
        rd_seen = 1'b0; tx_low = 1'b0; r0 = rd_cnt[0];
        enable_v[0] = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (rd_v[0] !== 1'b0) rd_seen = 1'b1;
            if (tx_v[0] !== 1'b1) tx_low = 1'b1;
        end
        n_cmp++;
        if (rd_seen || rd_cnt[0] != r0) begin n_mis++; $display("FAIL empty_pop: got %b expected 0", rd_seen); end
        n_cmp++;
        if (tx_low) begin n_mis++; $display("FAIL empty_tx: got %b expected 0", tx_low); end
        enable_v[0] = 1'b0;
    endtask

    task automatic test_enable_drop();
        int r0; int d0; bit ok; frame_t r; frame_t e;
        r0 = rd_cnt[0]; d0 = done_cnt[0];
        push(0, 8'h3C, 1'b1); push(0, 8'hC5, 1'b1);
        enable_v[0] = 1'b1;
        for (int k = 0; k < 20 && rd_cnt[0] == r0; k++) @(negedge clk);
        repeat (3 * CPB + 1) @(negedge clk);
        enable_v[0] = 1'b0;
        wait_frames(0, d0 + 1, 200, ok);
        repeat (60) @(negedge clk);
        n_cmp++;
        if (!ok || rd_cnt[0] - r0 != 1 || empty_v[0] !== 1'b0) begin
            n_mis++; $display("FAIL drop_hold: got %0d pops expected 1", rd_cnt[0] - r0);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                enable_v[0] = 1'b1;
                wait_frames(0, d0 + 2, 200, ok);
                repeat (3) @(negedge clk);
            end
            n_cmp++;
            if (rx_q.size() != 1) begin
                n_mis++; $display("FAIL drop_frame%0d: got %0d frames expected 1", k, rx_q.size());
            end else begin
                r = rx_q.pop_front(); e = exp_q.pop_front();
                if (r.bits !== e.bits) begin n_mis++; $display("FAIL drop_bits%0d: got %b expected %b", k, r.bits, e.bits); end
            end
        end
        n_cmp++;
        if (rd_cnt[0] - r0 != 2) begin n_mis++; $display("FAIL drop_pops: got %0d expected 2", rd_cnt[0] - r0); end
        enable_v[0] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int r0; int d0; bit ok; frame_t r; frame_t e;
        r0 = rd_cnt[0]; d0 = done_cnt[0];
        push(0, 8'h5A, 1'b0); push(0, 8'hC3, 1'b1);
        enable_v[0] = 1'b1;
        for (int k = 0; k < 20 && rd_cnt[0] == r0; k++) @(negedge clk);
        repeat (5 * CPB) @(negedge clk);
        enable_v[0] = 1'b0;
        n_cmp++;
        if (busy_v[0] !== 1'b1) begin n_mis++; $display("FAIL rst_pre_busy: got %b expected 1", busy_v[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx_v[0], busy_v[0], rd_v[0], done_v[0]} !== 4'b1000) begin
            n_mis++; $display("FAIL rst_mid: got %b expected 1000", {tx_v[0], busy_v[0], rd_v[0], done_v[0]});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        enable_v[0] = 1'b1;
        wait_frames(0, d0 + 1, 200, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok || rx_q.size() != 1) begin
            n_mis++; $display("FAIL rst_frame: got %0d frames expected 1", rx_q.size());
        end else begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r.bits !== e.bits) begin n_mis++; $display("FAIL rst_bits: got %b expected %b", r.bits, e.bits); end
        end
        n_cmp++;
        if (rd_cnt[0] - r0 != 2 || empty_v[0] !== 1'b1) begin
            n_mis++; $display("FAIL rst_pops: got %0d expected 2", rd_cnt[0] - r0);
        end
        enable_v[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_parity();
        test_empty_idle();
        test_enable_drop();
        test_reset_mid_frame();
        n_cmp++;
        if (exp_q.size() != 0 || rx_q.size() != 0) begin
            n_mis++; $display("FAIL leftovers: got %0d/%0d expected 0/0", exp_q.size(), rx_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
